// File: rtl/bcd_decade_counter_n.sv
// bcd_decade_counter_n: cascaded decimal up/down counter with a selectable
// digit code (8421, 2421 Aiken, excess-3) on the load input and count output.
// Digits are held internally as plain 0..9 values, so a code change only
// alters the combinational encoding of q and never the stored count.
module bcd_decade_counter_n #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  load_err
);

    typedef enum logic [1:0] {
        CODE_8421     = 2'b00,
        CODE_2421     = 2'b01,
        CODE_XS3      = 2'b10,
        CODE_8421_ALT = 2'b11
    } code_e;

    code_e code;
    assign code = code_e'(mode);

    // Digit value 0..9 to its code word.
    function automatic logic [3:0] enc_digit(input logic [3:0] v, input code_e c);
        logic [3:0] w;
        case (c)
            CODE_2421: w = (v < 4'd5) ? v : v + 4'd6;
            CODE_XS3:  w = v + 4'd3;
            default:   w = v;
        endcase
        return w;
    endfunction

    // True when the code word is a legal digit in the given code.
    function automatic logic is_legal(input logic [3:0] n, input code_e c);
        logic ok;
        case (c)
            CODE_2421: ok = (n <= 4'd4) || (n >= 4'd11);
            CODE_XS3:  ok = (n >= 4'd3) && (n <= 4'd12);
            default:   ok = (n <= 4'd9);
        endcase
        return ok;
    endfunction

    // Code word to digit value; illegal words decode to 0.
    function automatic logic [3:0] dec_digit(input logic [3:0] n, input code_e c);
        logic [3:0] v;
        if (!is_legal(n, c)) begin
            v = 4'd0;
        end else begin
            case (c)
                CODE_2421: v = (n < 4'd5) ? n : n - 4'd6;
                CODE_XS3:  v = n - 4'd3;
                default:   v = n;
            endcase
        end
        return v;
    endfunction

    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [4*DIGITS-1:0] count_val;
    logic                load_err_q, load_err_d;
    logic                carry;
    logic                all9, all0;
    logic [3:0]          cur;
    logic [3:0]          nxt;

    // Encode the stored digits under the current code for the q output.
    always_comb begin
        q = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            q[4*i +: 4] = enc_digit(digits_q[4*i +: 4], code);
        end
    end

    // Ripple carry/borrow chain: a digit steps only when all lower digits
    // sit at their wrap value for the current direction.
    always_comb begin
        count_val = digits_q;
        carry     = 1'b1;
        all9      = 1'b1;
        all0      = 1'b1;
        cur       = 4'd0;
        nxt       = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            cur = digits_q[4*i +: 4];
            nxt = cur;
            if (carry) begin
                if (up) begin
                    nxt = (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
                end else begin
                    nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
                end
            end
            count_val[4*i +: 4] = nxt;
            carry = carry & (up ? (cur == 4'd9) : (cur == 4'd0));
            all9  = all9 & (cur == 4'd9);
            all0  = all0 & (cur == 4'd0);
        end
    end

    assign tc       = en & (up ? all9 : all0);
    assign load_err = load_err_q;

    // Next-state select: load beats count, count beats hold.
    always_comb begin
        digits_d   = digits_q;
        load_err_d = 1'b0;
        if (load) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digits_d[4*i +: 4] = dec_digit(d[4*i +: 4], code);
                if (!is_legal(d[4*i +: 4], code)) begin
                    load_err_d = 1'b1;
                end
            end
        end else if (en) begin
            digits_d = count_val;
        end
    end

    // State registers with synchronous active-low reset taking top priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            digits_q   <= '0;
            load_err_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            load_err_q <= load_err_d;
        end
    end

endmodule

// File: doc/bcd_decade_counter_n.md
BCD_DECADE_COUNTER_N -- requirements
Module: bcd_decade_counter_n

Interface
REQ-001 Parameter DIGITS, default 2, number of cascaded decade digits; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; low at a rising clk edge resets the block.
REQ-004 en  input  1  count enable; one count step per cycle while high.
REQ-005 up  input  1  direction; 1 = count up, 0 = count down.
REQ-006 load  input  1  parallel load strobe.
REQ-007 mode  input  2  digit code select:
- 00 = 8421 BCD
- 01 = 2421 (Aiken)
- 10 = excess-3
- 11 = same as 00
REQ-008 d  input  4*DIGITS  load value in the code selected by mode; digit 0 at d[3:0].
REQ-009 q  output  4*DIGITS  count value in the code selected by mode; digit 0 at q[3:0].
REQ-010 tc  output  1  terminal count.
REQ-011 load_err  output  1  illegal code word detected on the previous load.

Function
REQ-012 Internal state SHALL be DIGITS decimal digit registers, each 0..9; the code is independent of mode.
REQ-013 q SHALL be the combinational encoding of the digit registers under the current mode. A mode change SHALL alter q in the same cycle without altering the digit registers.
REQ-014 Encodings SHALL be:
- 8421: value 0..9 -> 0000..1001
- 2421: 0..4 -> 0000..0100; 5..9 -> 1011..1111
- excess-3: value+3 -> 0011..1100
REQ-015 Priority per edge SHALL be: reset low > load > en > hold.
REQ-016 On load, each digit SHALL take the decoded value of its d nibble; load SHALL ignore en and up.
REQ-017 An illegal nibble SHALL load 0 into that digit and still load all legal digits. Illegal nibbles are:
- 8421: 1010..1111
- 2421: 0101..1010
- excess-3: 0000..0010 and 1101..1111
REQ-018 load_err SHALL be registered: high for exactly the one cycle after a load containing at least one illegal nibble; low otherwise, including after a legal load and after non-load cycles.
REQ-019 Counting up, digit 0 SHALL increment every enabled cycle. Digit k SHALL increment only when digits 0..k-1 are all 9. A digit at 9 that increments SHALL wrap to 0.
REQ-020 Counting down, digit 0 SHALL decrement every enabled cycle. Digit k SHALL decrement only when digits 0..k-1 are all 0. A digit at 0 that decrements SHALL wrap to 9.
REQ-021 Whole-counter wrap: all 9s + up -> all 0s; all 0s + down -> all 9s, with no stall cycle.
REQ-022 tc SHALL be combinational: en & ((up & all digits 9) | (~up & all digits 0)); tc SHALL be 0 when en is 0.
REQ-023 A change of up SHALL take effect on the next edge with no extra step and no lost count.
REQ-024 With en low and load low, all state SHALL hold.
REQ-025 The digit registers SHALL never hold a value above 9 under any input sequence.

Reset
REQ-026 reset low at an edge SHALL clear all digits to 0 and load_err to 0, regardless of load/en.
REQ-027 Post-reset q SHALL be 0x00..0 in 8421/2421 and 0x33..3 in excess-3 (DIGITS=2: 8'h33).
REQ-028 reset asserted mid-count or concurrently with load SHALL win. Counting SHALL resume from 0 on the first edge with reset high.
REQ-029 No state SHALL depend on an initial block; behaviour before the first reset edge is undefined.

Verification (DIGITS=2)
REQ-030 Reset, mode=00, up=1, en=1 for 100 cycles -> q steps 00..99 then 00; tc=1 only while q=8'h99.
REQ-031 mode=01, count up from 0 -> digit 0 sequence 0000,0001,0010,0011,0100,1011,1100,1101,1110,1111,0000; at 4->5 q goes 8'h04 -> 8'h0B; at 9->10 q goes 8'h0F -> 8'h10.
REQ-032 mode=10, load d=8'h33 (value 00), up=0, en=1 -> next q=8'hCC (99), tc=1 in the cycle before the wrap, load_err=0.
REQ-033 mode=01, load d=8'h75 (both nibbles illegal in 2421) -> digits 00, load_err=1 for one cycle then 0. Load d=8'h1B (legal in 2421) -> value 15, q=8'h1B, load_err=0.
REQ-034 Counting at value 47 with en=1, assert reset low together with load=1, d=8'h99 -> q=0, load_err=0; release reset -> next edge value 01.
REQ-035 Hold value 58 in mode=00, switch mode 00->01->10 with en=0 -> q = 8'h58, 8'hBE, 8'h8B; digits unchanged.
